// File: rtl/iter_div_unit_pkg.sv
// Shared divider definitions: FSM state encoding and the op-field bit positions
// the execute stage uses to select quotient vs remainder.
package iter_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

    // Divider-op field: bit 0 selects signed, bit 1 selects remainder as the writeback value
    localparam int DIV_OP_W          = 2;
    localparam int DIV_OP_SIGNED_BIT = 0;
    localparam int DIV_OP_REM_BIT    = 1;

endpackage

// File: rtl/iter_div_unit_operand_prep.sv
// Combinational operand preparation for the divider: magnitudes, result signs,
// zero-divisor detect and (with DIV_BYPASS_EN defined) the early-exit compare.
module div_operand_prep #(
    parameter int WIDTH = 32
) (
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             q_neg,
    output logic             r_neg,
    output logic             b_zero,
    output logic             bypass
);

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    always_comb begin
        a_neg  = is_signed & a[WIDTH-1];
        b_neg  = is_signed & b[WIDTH-1];
        a_abs  = a_neg ? (~a + 1'b1) : a;
        b_abs  = b_neg ? (~b + 1'b1) : b;
        b_zero = (b == '0);
        // With b==0 every iteration sets a quotient one and the remainder collects
        // the raw dividend bits, so feeding a unmodified and dropping signs yields q=~0, r=a.
        a_mag  = b_zero ? a : a_abs;
        b_mag  = b_abs;
        q_neg  = !b_zero & (a_neg ^ b_neg);
        r_neg  = !b_zero & a_neg;
`ifdef DIV_BYPASS_EN
        bypass = b_zero | (a_abs < b_abs);
`else
        bypass = 1'b0;
`endif
    end

endmodule

// File: rtl/iter_div_unit.sv
// Restoring radix-2 integer divider, one quotient bit per cycle, signed/unsigned, flushable.
// Define DIV_BYPASS_EN to finish b==0 and |a|<|b| ops in a single cycle.
module iter_div_unit
    import iter_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quot,
    output logic [WIDTH-1:0] out_rem,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_dbz
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state, state_d;
    logic             accept;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] prem;      // partial remainder, always < |b| between steps
    logic [WIDTH-1:0] dvd;       // dividend bits shift out the top, quotient bits in the bottom
    logic [WIDTH-1:0] dsr;
    logic             q_neg_r, r_neg_r, dbz_r;
    logic [TAG_W-1:0] tag_r;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             q_neg, r_neg, b_zero, bypass;

    logic [WIDTH:0]   p_shift;
    logic [WIDTH:0]   p_diff;
    logic             q_bit;
    logic [WIDTH-1:0] p_next, dvd_next, q_final, r_final;

    div_operand_prep #(.WIDTH(WIDTH)) u_prep (
        .is_signed (in_signed),
        .a         (in_dividend),
        .b         (in_divisor),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .q_neg     (q_neg),
        .r_neg     (r_neg),
        .b_zero    (b_zero),
        .bypass    (bypass)
    );

    always_comb begin
        state_d  = state;
        in_ready = 1'b0;
        case (state)
            DIV_ST_IDLE: in_ready = !flush;
            DIV_ST_BUSY: if (cnt == '0) state_d = DIV_ST_DONE;
            DIV_ST_DONE: begin
                in_ready = !flush && out_ready;
                if (out_ready) state_d = DIV_ST_IDLE;
            end
            default:     state_d = DIV_ST_IDLE;
        endcase
        accept = in_valid && in_ready;
        if (accept) state_d = bypass ? DIV_ST_DONE : DIV_ST_BUSY;
        if (flush)  state_d = DIV_ST_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= DIV_ST_IDLE;
        else         state <= state_d;
    end

    // A set top bit of p_shift already exceeds any divisor; otherwise bit WIDTH of the
    // difference is the borrow.
    always_comb begin
        p_shift  = {prem, dvd[WIDTH-1]};
        p_diff   = p_shift - {1'b0, dsr};
        q_bit    = p_shift[WIDTH] | !p_diff[WIDTH];
        p_next   = q_bit ? p_diff[WIDTH-1:0] : p_shift[WIDTH-1:0];
        dvd_next = {dvd[WIDTH-2:0], q_bit};
        q_final  = q_neg_r ? (~dvd_next + 1'b1) : dvd_next;
        r_final  = r_neg_r ? (~p_next + 1'b1) : p_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            prem     <= '0;
            dvd      <= '0;
            dsr      <= '0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            dbz_r    <= 1'b0;
            tag_r    <= '0;
            out_quot <= '0;
            out_rem  <= '0;
            out_tag  <= '0;
            out_dbz  <= 1'b0;
        end else if (accept) begin
            cnt     <= CNT_W'(WIDTH-1);
            prem    <= '0;
            dvd     <= a_mag;
            dsr     <= b_mag;
            q_neg_r <= q_neg;
            r_neg_r <= r_neg;
            dbz_r   <= b_zero;
            tag_r   <= in_tag;
            if (bypass) begin
                out_quot <= b_zero ? '1 : '0;
                out_rem  <= in_dividend;
                out_tag  <= in_tag;
                out_dbz  <= b_zero;
            end
        end else if (state == DIV_ST_BUSY) begin
            cnt  <= cnt - 1'b1;
            prem <= p_next;
            dvd  <= dvd_next;
            if (cnt == '0) begin
                out_quot <= q_final;
                out_rem  <= r_final;
                out_tag  <= tag_r;
                out_dbz  <= dbz_r;
            end
        end
    end

    assign out_valid = (state == DIV_ST_DONE);

endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: stimulus pushes model results, a monitor pops and checks them.
module tb_iter_div_unit;

    localparam int W  = 32;
    localparam int TW = 5;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_signed = 1'b0;
    logic [W-1:0]  in_dividend = '0;
    logic [W-1:0]  in_divisor = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_quot;
    logic [W-1:0]  out_rem;
    logic [TW-1:0] out_tag;
    logic          out_dbz;

    typedef struct {
        logic [W-1:0]  q;
        logic [W-1:0]  r;
        logic [TW-1:0] tag;
        logic          dbz;
        int            acc;
        int            lat;
        bit            seen;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   bp_en = 1'b0;

    iter_div_unit #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_signed   (in_signed),
        .in_dividend (in_dividend),
        .in_divisor  (in_divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_quot    (out_quot),
        .out_rem     (out_rem),
        .out_tag     (out_tag),
        .out_dbz     (out_dbz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (bp_en) out_ready = ($urandom_range(0, 3) != 0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division on 64-bit values, truncating toward zero.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic s, input logic [TW-1:0] t, input int acc);
        exp_t   e;
        longint sa, sb_, ma, mb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb_ = s ? longint'($signed(b)) : longint'(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb_ < 0) ? -sb_ : sb_;
        e.tag = t;
        e.dbz = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
            e.q = W'(sa / sb_);
            e.r = W'(sa % sb_);
        end
        e.acc  = acc;
        e.seen = 1'b0;
`ifdef DIV_BYPASS_EN
        e.lat = (b == '0 || ma < mb) ? 1 : W + 1;
`else
        e.lat = W + 1;
`endif
        return e;
    endfunction

    // Monitor: samples after the stimulus has settled for the coming edge.
    initial forever begin
        @(negedge clk);
        #2;
        if (resetn && out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                if (!sb[0].seen) begin
                    chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                    sb[0].seen = 1'b1;
                end
                chk("quot", 64'(out_quot), 64'(sb[0].q));
                chk("rem",  64'(out_rem),  64'(sb[0].r));
                chk("tag",  64'(out_tag),  64'(sb[0].tag));
                chk("dbz",  64'(out_dbz),  64'(sb[0].dbz));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic [TW-1:0] t, input bit rdy_now, output int waited);
        waited = 0;
        @(negedge clk);
        if (rdy_now) out_ready = 1'b1;
        in_valid = 1'b1; in_dividend = a; in_divisor = b; in_signed = s; in_tag = t;
        #1;
        while (!in_ready && waited < 500) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready 0 expected 1 (cycle %0d)", cyc);
        end else begin
            sb.push_back(model(a, b, s, t, cyc));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    function automatic logic [W-1:0] rnd_operand(input bit divisor);
        case ($urandom_range(0, 6))
            0:       return divisor ? 32'd0 : 32'($urandom_range(0, 3));
            1:       return 32'($urandom_range(1, 20));
            2:       return MIN;
            3:       return '1;
            4:       return 32'($urandom_range(0, 65535));
            5:       return -32'($urandom_range(1, 40));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        int w;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_quot",  64'(out_quot),  64'd0);
        chk("rst_out_rem",   64'(out_rem),   64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_dbz",   64'(out_dbz),   64'd0);
        resetn = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);

        // Reference vectors
        issue(32'd100, 32'd7, 1'b0, 5'd3, 1'b0, w);
        issue(-32'd7, 32'd2, 1'b1, 5'd4, 1'b0, w);
        issue(32'd7, -32'd2, 1'b1, 5'd5, 1'b0, w);
        issue(MIN, '1, 1'b1, 5'd6, 1'b0, w);
        issue(MIN, '1, 1'b0, 5'd7, 1'b0, w);
        issue(32'd5, 32'd0, 1'b1, 5'd8, 1'b0, w);
        issue(32'd5, 32'd0, 1'b0, 5'd9, 1'b0, w);
        drain();

        // Flush at BUSY cycle 10
        issue(32'd1000, 32'd3, 1'b0, 5'd10, 1'b0, w);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post_flush_in_ready", 64'(in_ready), 64'd1);
        chk("post_flush_valid", 64'(out_valid), 64'd0);
        repeat (40) @(negedge clk);
        issue(32'd1000, 32'd3, 1'b0, 5'd11, 1'b0, w);
        drain();

        // Reset pulse mid-BUSY
        issue(32'd12345, 32'd17, 1'b0, 5'd12, 1'b0, w);
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_quot",  64'(out_quot),  64'd0);
        void'(sb.pop_back());
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (40) @(negedge clk);
        issue(-32'd12345, 32'd17, 1'b1, 5'd13, 1'b0, w);
        drain();

        // Backpressure in DONE, then same-cycle release and re-issue
        out_ready = 1'b0;
        issue(32'd77, 32'd5, 1'b0, 5'd14, 1'b0, w);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk("bp_valid_rise", 64'(out_valid), 64'd1);
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
        end
        issue(32'd999, 32'd10, 1'b0, 5'd15, 1'b1, w);
        chk("same_cycle_accept", 64'(w), 64'd0);
        drain();

        // Random traffic with consumer backpressure
        bp_en = 1'b1;
        for (int i = 0; i < 120; i++) begin
            issue(rnd_operand(1'b0), rnd_operand(1'b1), 1'($urandom_range(0, 1)),
                  TW'($urandom), 1'b0, w);
        end
        bp_en = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
